// File: rtl/text_pixel_pipe_if.sv
// rtl/text_pixel_pipe_if.sv - position, memory and pixel signals of the text pixel pipe
interface text_pixel_pipe_if;
  logic [9:0]  dot_counter;
  logic [8:0]  scanline_counter;
  logic [11:0] cursor_pos;
  logic        cursor_en;
  logic [11:0] char_addr;
  logic [7:0]  char_data;
  logic [10:0] font_addr;
  logic [7:0]  font_data;
  logic        pixel_on;
  logic        pixel_valid;

  modport master (
    output dot_counter, scanline_counter, cursor_pos, cursor_en, char_data, font_data,
    input  char_addr, font_addr, pixel_on, pixel_valid
  );

  modport slave (
    input  dot_counter, scanline_counter, cursor_pos, cursor_en, char_data, font_data,
    output char_addr, font_addr, pixel_on, pixel_valid
  );
endinterface

// File: rtl/text_pixel_pipe.sv
// rtl/text_pixel_pipe.sv - text RAM / font ROM fetch and glyph serialiser, 3-clock latency
module text_pixel_pipe #(
  parameter int H_VISIBLE    = 640,
  parameter int V_VISIBLE    = 480,
  parameter int COLS         = 80,
  parameter int BLINK_FRAMES = 30
) (
  input logic              clk,
  input logic              rst,
  text_pixel_pipe_if.slave vid
);

  localparam logic [9:0] H_VIS = 10'(H_VISIBLE);
  localparam logic [8:0] V_VIS = 9'(V_VISIBLE);
  localparam int         CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);

  logic [6:0]  col;
  logic [3:0]  glyph_row;
  logic [4:0]  text_row;
  logic [11:0] char_addr_w;
  logic        vis_w;
  logic        frame_start;
  logic        cursor_hit;

  logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             blink_phase_q, blink_phase_d;

  logic       vis_s1_q, cur_s1_q;
  logic [2:0] dotx_s1_q;
  logic [3:0] grow_s1_q;

  logic       vis_s2_q, cur_s2_q, inv_s2_q;
  logic [2:0] dotx_s2_q;
  logic [3:0] grow_s2_q;

  logic pixel_on_q, pixel_valid_q;
  logic dot_bit;

  always_comb begin
    col         = vid.dot_counter[9:3];
    glyph_row   = vid.scanline_counter[3:0];
    text_row    = vid.scanline_counter[8:4];
    char_addr_w = 12'(text_row) * 12'(COLS) + 12'(col);
    vis_w       = (vid.dot_counter < H_VIS) && (vid.scanline_counter < V_VIS);
    frame_start = (vid.dot_counter == 10'd0) && (vid.scanline_counter == 9'd0);
    cursor_hit  = vid.cursor_en && (char_addr_w == vid.cursor_pos);
  end

  always_comb begin
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_start) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
    end else begin
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  // The blink phase is folded into the cursor flag at sample time, so a
  // toggle on a frame-start edge never reaches dots already in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      vis_s1_q  <= 1'b0;
      cur_s1_q  <= 1'b0;
      dotx_s1_q <= '0;
      grow_s1_q <= '0;
      vis_s2_q  <= 1'b0;
      cur_s2_q  <= 1'b0;
      inv_s2_q  <= 1'b0;
      dotx_s2_q <= '0;
      grow_s2_q <= '0;
    end else begin
      vis_s1_q  <= vis_w;
      cur_s1_q  <= cursor_hit && blink_phase_d;
      dotx_s1_q <= vid.dot_counter[2:0];
      grow_s1_q <= glyph_row;
      vis_s2_q  <= vis_s1_q;
      cur_s2_q  <= cur_s1_q;
      inv_s2_q  <= vid.char_data[7];
      dotx_s2_q <= dotx_s1_q;
      grow_s2_q <= grow_s1_q;
    end
  end

  always_comb begin
    dot_bit = vid.font_data[3'd7 - dotx_s2_q];
    if (cur_s2_q && (grow_s2_q >= 4'd14)) begin
      dot_bit = 1'b1;
    end
    dot_bit = dot_bit ^ inv_s2_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_on_q    <= 1'b0;
      pixel_valid_q <= 1'b0;
    end else begin
      pixel_on_q    <= vis_s2_q && dot_bit;
      pixel_valid_q <= vis_s2_q;
    end
  end

  assign vid.char_addr   = char_addr_w;
  assign vid.font_addr   = {vid.char_data[6:0], grow_s1_q};
  assign vid.pixel_on    = pixel_on_q;
  assign vid.pixel_valid = pixel_valid_q;

endmodule

// File: tb/tb_text_pixel_pipe.sv
// tb/tb_text_pixel_pipe.sv - directed bench for text_pixel_pipe
module tb_text_pixel_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total = 0;

  logic [7:0] ram  [4096];
  logic [7:0] font [2048];

  logic pend_chk [3];
  logic pend_v   [3];
  logic pend_o   [3];

  text_pixel_pipe_if vif();

  text_pixel_pipe dut (
    .clk (clk),
    .rst (rst),
    .vid (vif.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    vif.char_data <= ram[vif.char_addr];
    vif.font_data <= font[vif.font_addr];
  end

  task check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task clear_pend();
    for (int i = 0; i < 3; i++) begin
      pend_chk[i] = 1'b1;
      pend_v[i]   = 1'b0;
      pend_o[i]   = 1'b0;
    end
  endtask

  // One dot per call: checks the output of the dot driven three calls ago,
  // then drives this dot and queues its expected output.
  task cyc(input logic [9:0] d, input logic [8:0] s, input logic ev, input logic eo,
           input logic r = 1'b0);
    @(negedge clk);
    if (pend_chk[2]) begin
      check("pixel_valid", vif.pixel_valid, pend_v[2]);
      check("pixel_on", vif.pixel_on, pend_o[2]);
    end
    for (int i = 2; i > 0; i--) begin
      pend_chk[i] = pend_chk[i-1];
      pend_v[i]   = pend_v[i-1];
      pend_o[i]   = pend_o[i-1];
    end
    rst = r;
    vif.dot_counter      = d;
    vif.scanline_counter = s;
    if (r) begin
      clear_pend();
    end else begin
      pend_chk[0] = 1'b1;
      pend_v[0]   = ev;
      pend_o[0]   = eo;
    end
  endtask

  task fs_pairs(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(10'd0, 9'd0, 1'b1, 1'b1);
      cyc(10'd1, 9'd0, 1'b1, 1'b0);
    end
  endtask

  initial begin
    logic [7:0] exp_a;
    logic [7:0] exp_b;
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    for (int i = 0; i < 2048; i++) font[i] = 8'h00;
    ram[0]          = 8'h41;
    font[11'h410]   = 8'h81;
    ram[81]         = 8'hC1;
    font[11'h415]   = 8'h81;
    ram[80]         = 8'h80;
    ram[160]        = 8'h80;
    for (int i = 0; i < 3; i++) begin
      pend_chk[i] = 1'b0;
      pend_v[i]   = 1'b0;
      pend_o[i]   = 1'b0;
    end
    vif.dot_counter      = 10'd0;
    vif.scanline_counter = 9'd0;
    vif.cursor_en        = 1'b0;
    vif.cursor_pos       = 12'd0;

    repeat (2) begin
      @(negedge clk);
      check("reset_pixel_valid", vif.pixel_valid, 1'b0);
      check("reset_pixel_on", vif.pixel_on, 1'b0);
    end
    clear_pend();

    exp_a = 8'b1000_0001;
    for (int i = 0; i < 8; i++) begin
      cyc(10'(i), 9'd0, 1'b1, exp_a[7-i]);
      if (i == 0) begin
        #1 check("char_addr_cell0", vif.char_addr, 12'd0);
      end
      if (i == 1) begin
        #1 check("font_addr_cell0", vif.font_addr, 11'h410);
      end
    end

    exp_b = 8'b0111_1110;
    for (int i = 0; i < 8; i++) begin
      cyc(10'(8 + i), 9'd21, 1'b1, exp_b[7-i]);
      if (i == 0) begin
        #1 check("char_addr_cell81", vif.char_addr, 12'd81);
      end
    end

    cyc(10'd639, 9'd15, 1'b1, 1'b0);
    #1 check("char_addr_dot639", vif.char_addr, 12'd79);
    cyc(10'd0, 9'd16, 1'b1, 1'b1);
    #1 check("char_addr_wrap", vif.char_addr, 12'd80);
    cyc(10'd640, 9'd16, 1'b0, 1'b0);
    #1 check("char_addr_blank", vif.char_addr, 12'd160);

    vif.cursor_en  = 1'b1;
    vif.cursor_pos = 12'd5;
    for (int i = 0; i < 8; i++) cyc(10'(40 + i), 9'd14, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) cyc(10'(40 + i), 9'd15, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) cyc(10'(40 + i), 9'd13, 1'b1, 1'b0);

    fs_pairs(28);
    cyc(10'd40, 9'd14, 1'b1, 1'b1);
    cyc(10'd0, 9'd0, 1'b1, 1'b1);
    cyc(10'd41, 9'd14, 1'b1, 1'b0);
    cyc(10'd42, 9'd15, 1'b1, 1'b0);

    fs_pairs(29);
    cyc(10'd43, 9'd15, 1'b1, 1'b0);
    cyc(10'd0, 9'd0, 1'b1, 1'b1);
    cyc(10'd44, 9'd15, 1'b1, 1'b1);
    cyc(10'd45, 9'd14, 1'b1, 1'b1);
    cyc(10'd46, 9'd13, 1'b1, 1'b0);

    fs_pairs(31);
    cyc(10'd47, 9'd14, 1'b1, 1'b0);
    for (int i = 297; i < 300; i++) cyc(10'(i), 9'd100, 1'b1, 1'b0);
    cyc(10'd300, 9'd100, 1'b0, 1'b0, 1'b1);
    for (int i = 301; i < 306; i++) cyc(10'(i), 9'd100, 1'b1, 1'b0);
    cyc(10'd40, 9'd14, 1'b1, 1'b1);
    fs_pairs(29);
    cyc(10'd41, 9'd15, 1'b1, 1'b1);

    repeat (3) cyc(10'd640, 9'd480, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/text_pixel_pipe.md
Name: text_pixel_pipe

Overview:
- Downstream consumer of text_counters in the LC3 text-mode video path.
- Takes the current dot_counter/scanline_counter position and fetches the character code from text RAM, then the glyph row from font ROM.
- Serialises one glyph bit per dot as pixel_on, with inverse-video and a blinking underline cursor.
- Output is position-aligned 3 clocks after the counter values that produced it; the sync/colour stage consumes it.

Parameters:
- H_VISIBLE, 640, visible dots per scanline; dot_counter >= H_VISIBLE is blank.
- V_VISIBLE, 480, visible scanlines; scanline_counter >= V_VISIBLE is blank.
- COLS, 80, character cells per row (8-dot-wide glyphs).
- BLINK_FRAMES, 30, frames per cursor blink half-period.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- dot_counter  in  10  current dot, from text_counters
- scanline_counter  in  9  current scanline, from text_counters
- cursor_pos  in  12  cell index of cursor (row*COLS+col)
- cursor_en  in  1  1 = cursor displayed
- char_addr  out  12  text RAM read address
- char_data  in  8  text RAM data; 1-cycle synchronous read latency; bit7 = inverse, [6:0] = code
- font_addr  out  11  font ROM address {code[6:0], glyph_row[3:0]}
- font_data  in  8  font ROM data; 1-cycle latency; bit7 = leftmost dot
- pixel_on  out  1  1 = foreground at this dot
- pixel_valid  out  1  1 = the dot for pixel_on is in the visible region

Behaviour:
- Reset: all pipeline registers, pixel_on, pixel_valid and blink_cnt clear to 0; blink_phase = 1.
- Reset mid-frame forces pixel_on = pixel_valid = 0 on the next edge.
- Output stays 0 until 3 valid pipeline stages refill after reset.
- Cell decode, combinational from inputs at cycle N:
  - col = dot_counter[9:3], glyph_row = scanline_counter[3:0], text_row = scanline_counter[8:4].
  - char_addr = text_row*COLS + col, truncated to 12 bits.
- Stage 1 (edge ending cycle N):
  - Register vis = (dot < H_VISIBLE) && (scan < V_VISIBLE), dot[2:0], glyph_row, and cursor_hit = cursor_en && (char_addr == cursor_pos).
- Cycle N+1:
  - font_addr = {char_data[6:0], glyph_row_s1}, combinational.
  - Stage 2 registers inv = char_data[7] plus the stage-1 sideband.
- Cycle N+2 (font_data valid):
  - bit = font_data[7 - dotx_s2].
  - If cursor_hit_s2 && blink_phase && glyph_row_s2 >= 14, force bit = 1.
  - Then apply bit ^= inv_s2.
  - Stage 3 registers pixel_on = vis_s2 ? bit : 0 and pixel_valid = vis_s2.
- Latency: exactly 3 clocks from counter inputs to pixel_on/pixel_valid. char_addr and font_addr are combinational, with no added latency.
- Blink:
  - A frame start is a cycle with dot_counter == 0 && scanline_counter == 0.
  - On each frame start, blink_cnt increments. When blink_cnt reaches BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles.
  - A blink_phase change applies only to dots sampled on or after the frame-start cycle; there is no mid-frame tearing beyond that.
- Blank region:
  - Addresses still toggle, which is harmless.
  - pixel_on is held at 0 and the cursor/inverse logic is ignored.
  - char_addr may exceed 2399 when blank; the RAM must tolerate this.
- Boundary: dot 639 and dot 0 of the next line are consecutive inputs. The pipeline must not stall or bubble on wrap; every input cycle yields one output cycle.
- No handshake: one dot per clock, continuous.

Test Plan:
- Reset 2 cycles, RAM all 0x00, font all 0x00 -> pixel_on = 0, pixel_valid = 0 during reset; pixel_valid = 1 exactly 3 clocks after first visible dot.
- RAM[0] = 0x41, font[{0x41,0}] = 0x81, dot 0..7 at scanline 0 -> char_addr = 0, font_addr = 0x410, pixel_on sequence 1,0,0,0,0,0,0,1 starting 3 clocks later.
- RAM[81] = 0xC1 (inverse), font row 5 = 0x81, scanline 21, dots 8..15 -> char_addr = 81, pixel_on 0,1,1,1,1,1,1,0.
- dot 639 then 0 across scanline 15->16 -> char_addr 79 then 80, no bubble, pixel_valid stays 1; dot 640 -> pixel_valid = 0 and pixel_on = 0 three clocks later.
- cursor_en = 1, cursor_pos = 5, blank glyph:
  - glyph rows 14,15 of cell 5 -> pixel_on = 1 for all 8 dots; row 13 -> 0.
  - After 30 frame starts, cursor rows read 0; after 60, they read 1.
- Assert rst mid-line at dot 300 for 1 cycle -> pixel_on = pixel_valid = 0 next edge; blink_cnt = 0, blink_phase = 1; valid output resumes 3 clocks after rst drops.
